// File: rtl/dqn_step_sequencer.sv
// dqn_step_sequencer: per-step FWD->ACT->ENV->UPD->NEXT training sequencer owning step/episode/epsilon counters.
// Latency: each phase costs >= 2 cycles (start-pulse cycle + done cycle), NEXT costs 1, so >= 9 cycles per step.
// Backpressure: waits indefinitely for each sub-unit done; halt pauses cleanly at the next step boundary.
module dqn_step_sequencer #(
    parameter int STATE_W      = 4,
    parameter int GOAL_STATE   = 9,
    parameter int MAX_STEPS    = 15,
    parameter int EP_W         = 12,
    parameter int NUM_EPISODES = 100,
    parameter int EPS_W        = 8,
    parameter int EPS_INIT     = 255,
    parameter int EPS_DEC      = 2,
    parameter int EPS_MIN      = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               halt,
    input  logic [STATE_W-1:0] st_next,
    output logic               fwd_start,
    input  logic               fwd_done,
    output logic               act_start,
    input  logic               act_done,
    output logic               env_start,
    input  logic               env_done,
    output logic               upd_start,
    input  logic               upd_done,
    output logic               busy,
    output logic               train_done,
    output logic [3:0]         step,
    output logic [EP_W-1:0]    episode,
    output logic [EPS_W-1:0]   epsilon,
    output logic [2:0]         phase
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FWD  = 3'd1;
    localparam logic [2:0] S_ACT  = 3'd2;
    localparam logic [2:0] S_ENV  = 3'd3;
    localparam logic [2:0] S_UPD  = 3'd4;
    localparam logic [2:0] S_NEXT = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    localparam logic [STATE_W-1:0] GOAL_S    = STATE_W'(GOAL_STATE);
    localparam logic [3:0]         STEP_MAX  = 4'(MAX_STEPS);
    localparam logic [EP_W-1:0]    EP_TARGET = EP_W'(NUM_EPISODES);
    localparam logic [EPS_W-1:0]   EPS_RST   = EPS_W'(EPS_INIT);
    localparam logic [EPS_W-1:0]   EPS_STEP  = EPS_W'(EPS_DEC);
    localparam logic [EPS_W-1:0]   EPS_FLOOR = EPS_W'(EPS_MIN);
    // Decrementing is only safe when the result stays at or above the floor.
    localparam logic [EPS_W:0]     EPS_THR   = (EPS_W+1)'(EPS_MIN + EPS_DEC);

    logic [2:0]         phase_q, phase_d;
    logic               entry_q, entry_d;   // high only in the first cycle of a phase state
    logic [3:0]         step_q, step_d;
    logic [EP_W-1:0]    episode_q, episode_d;
    logic [EPS_W-1:0]   eps_q, eps_d;
    logic [STATE_W-1:0] last_q, last_d;

    logic [EP_W-1:0]    ep_inc;
    logic [EPS_W-1:0]   eps_dec;
    logic               ep_end;

    // Episode-boundary helpers evaluated in NEXT: incremented count, end condition, floored epsilon.
    always_comb begin
        ep_inc = episode_q + 1'b1;
        ep_end = (last_q == GOAL_S) || (step_q == STEP_MAX);
        if ({1'b0, eps_q} >= EPS_THR) begin
            eps_dec = eps_q - EPS_STEP;
        end else begin
            eps_dec = EPS_FLOOR;
        end
    end

    // Phase sequencing; a done is honoured only after the entry cycle and only for the active phase.
    always_comb begin
        phase_d   = phase_q;
        entry_d   = 1'b0;
        step_d    = step_q;
        episode_d = episode_q;
        eps_d     = eps_q;
        last_d    = last_q;
        case (phase_q)
            S_IDLE: begin
                if (start) begin
                    phase_d = S_FWD;
                    entry_d = 1'b1;
                    last_d  = '0;
                    // step is 0 only straight after reset; a resume keeps the current step.
                    if (step_q == 4'd0) begin
                        step_d = 4'd1;
                    end
                end
            end
            S_FWD: begin
                if (!entry_q && fwd_done) begin
                    phase_d = S_ACT;
                    entry_d = 1'b1;
                end
            end
            S_ACT: begin
                if (!entry_q && act_done) begin
                    phase_d = S_ENV;
                    entry_d = 1'b1;
                end
            end
            S_ENV: begin
                if (!entry_q && env_done) begin
                    phase_d = S_UPD;
                    entry_d = 1'b1;
                    last_d  = st_next;
                end
            end
            S_UPD: begin
                if (!entry_q && upd_done) begin
                    phase_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (ep_end) begin
                    episode_d = ep_inc;
                    step_d    = 4'd1;
                    eps_d     = eps_dec;
                end else begin
                    step_d    = step_q + 4'd1;
                end
                if (ep_end && (ep_inc == EP_TARGET)) begin
                    phase_d = S_DONE;
                end else if (halt) begin
                    phase_d = S_IDLE;
                end else begin
                    phase_d = S_FWD;
                    entry_d = 1'b1;
                end
            end
            S_DONE: begin
                phase_d = S_DONE;
            end
            default: begin
                phase_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= S_IDLE;
            entry_q   <= 1'b0;
            step_q    <= 4'd0;
            episode_q <= '0;
            eps_q     <= EPS_RST;
            last_q    <= '0;
        end else begin
            phase_q   <= phase_d;
            entry_q   <= entry_d;
            step_q    <= step_d;
            episode_q <= episode_d;
            eps_q     <= eps_d;
            last_q    <= last_d;
        end
    end

    // Start pulses and status decoded from registered state.
    always_comb begin
        fwd_start  = entry_q && (phase_q == S_FWD);
        act_start  = entry_q && (phase_q == S_ACT);
        env_start  = entry_q && (phase_q == S_ENV);
        upd_start  = entry_q && (phase_q == S_UPD);
        busy       = (phase_q != S_IDLE) && (phase_q != S_DONE);
        train_done = (phase_q == S_DONE);
        step       = step_q;
        episode    = episode_q;
        epsilon    = eps_q;
        phase      = phase_q;
    end

endmodule
